// File: rtl/mem_io_responder.sv
// CPU-side memory/I-O responder: byte RAM, UART rx/tx ports, cycle counter, stop flag.
// Reads return on cpu_dout one cycle after acceptance; cpu_rdy stalls on empty rx or full tx FIFO.
module mem_io_responder #(
   parameter int RAM_AW   = 17,
   parameter int TX_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_dout,
   output logic        cpu_rdy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        program_done
);

   localparam int PW = $clog2(TX_DEPTH);

   logic [7:0]  ram [1 << RAM_AW];
   logic [7:0]  txq [TX_DEPTH];
   logic [PW:0] wptr, rptr;
   logic [31:0] cycle_cnt, snap;

   logic        io_sel, rx_rd, tx_req, full;
   logic        rd_en, wr_en, push, pop;
   logic [15:0] io_off;
   logic [7:0]  push_dat;
   logic        unused_a;

   assign unused_a = ^cpu_a[31:18];
   assign io_off   = cpu_a[15:0];
   assign io_sel   = (cpu_a[17:16] == 2'b11);
   assign rx_rd    = io_sel && !cpu_wr && (io_off == 16'h0000);
   assign tx_req   = io_sel && cpu_wr &&
                     (((io_off == 16'h0000) && (cpu_din != 8'h00)) || (io_off == 16'h0004));
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full     = ((wptr ^ rptr) == {1'b1, {PW{1'b0}}});

   assign cpu_rdy  = !rst_in && !(rx_rd && !rx_valid) && !(tx_req && full);
   assign rd_en    = cpu_rdy && !cpu_wr;
   assign wr_en    = cpu_rdy && cpu_wr;
   assign rx_ready = rd_en && rx_rd;
   assign push     = wr_en && tx_req;
   assign push_dat = (io_off == 16'h0004) ? 8'h00 : cpu_din;

   assign tx_valid = !rst_in && (wptr != rptr);
   assign tx_data  = txq[rptr[PW-1:0]];
   assign pop      = tx_valid && tx_ready;

   always_ff @(posedge clk_in) begin
      if (wr_en && !io_sel)
         ram[cpu_a[RAM_AW-1:0]] <= cpu_din;
   end

   always_ff @(posedge clk_in) begin
      if (push)
         txq[wptr[PW-1:0]] <= push_dat;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt    <= '0;
         snap         <= '0;
         program_done <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (rd_en && io_sel && (io_off == 16'h0004))
            snap <= cycle_cnt;
         if (push && (io_off == 16'h0004))
            program_done <= 1'b1;
      end
   end

   // Byte 0 comes straight from the live counter; bytes 1-3 come from the snapshot.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cpu_dout <= 8'h00;
      end else if (rd_en) begin
         if (!io_sel) begin
            cpu_dout <= ram[cpu_a[RAM_AW-1:0]];
         end else begin
            case (io_off)
               16'h0000: cpu_dout <= rx_data;
               16'h0004: cpu_dout <= cycle_cnt[7:0];
               16'h0005: cpu_dout <= snap[15:8];
               16'h0006: cpu_dout <= snap[23:16];
               16'h0007: cpu_dout <= snap[31:24];
               default:  cpu_dout <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, rx/tx I/O, counter snapshot, stop flag, reset.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] cpu_a = 32'h0;
   logic [7:0]  cpu_din = 8'h0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_dout;
   logic        cpu_rdy;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        program_done;

   int errors = 0;
   int checks = 0;
   logic [7:0] txlog [$];

   mem_io_responder #(.RAM_AW(17), .TX_DEPTH(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_wr(cpu_wr),
      .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .program_done(program_done)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in)
      if (!rst_in && tx_valid && tx_ready)
         txlog.push_back(tx_data);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
      cpu_a = a;
      cpu_wr = wr;
      cpu_din = d;
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h99;
      tx_ready = 1'b1;
      drive(32'h30000, 1'b0, 8'h00);
      repeat (3) step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", cpu_dout); end
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b want 0", cpu_rdy); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
      checks++; if (program_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", program_done); end
      rx_valid = 1'b0;
      tx_ready = 1'b0;
   endtask

   task automatic test_counter();
      rst_in = 1'b0;
      drive(32'h30004, 1'b0, 8'h00);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL cnt_rdy: got %b want 1", cpu_rdy); end
      step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL cnt_first: got %h want 00", cpu_dout); end
      drive(32'h00000, 1'b0, 8'h00);
      repeat (32'h1233 - 1) step();
      drive(32'h30004, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h33) begin errors++; $display("FAIL cnt_b0: got %h want 33", cpu_dout); end
      drive(32'h30005, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h12) begin errors++; $display("FAIL cnt_b1: got %h want 12", cpu_dout); end
      drive(32'h30006, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL cnt_b2: got %h want 00", cpu_dout); end
      drive(32'h30007, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL cnt_b3: got %h want 00", cpu_dout); end
   endtask

   task automatic test_ram();
      drive(32'h00010, 1'b1, 8'hA5);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL ram_wr_rdy: got %b want 1", cpu_rdy); end
      step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL ram_wr_hold: got %h want 00", cpu_dout); end
      drive(32'h00010, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL ram_raw: got %h want a5", cpu_dout); end
      drive(32'h1FFFF, 1'b1, 8'h5A);
      step();
      drive(32'h1FFFF, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL ram_top: got %h want 5a", cpu_dout); end
      drive(32'h20010, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL ram_alias: got %h want a5", cpu_dout); end
      drive(32'h10010, 1'b1, 8'hC3);
      step();
      drive(32'h00010, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL ram_bit16: got %h want a5", cpu_dout); end
      drive(32'h10010, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'hC3) begin errors++; $display("FAIL ram_hi: got %h want c3", cpu_dout); end
   endtask

   task automatic test_rx_stall();
      drive(32'h00010, 1'b0, 8'h00);
      step();
      rx_valid = 1'b0;
      drive(32'h30000, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL rx_stall_rdy[%0d]: got %b want 0", i, cpu_rdy); end
         checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_stall_pop[%0d]: got %b want 0", i, rx_ready); end
         checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL rx_stall_hold[%0d]: got %h want a5", i, cpu_dout); end
         step();
      end
      rx_data = 8'h41;
      rx_valid = 1'b1;
      #1;
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rx_go_rdy: got %b want 1", cpu_rdy); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_go_pop: got %b want 1", rx_ready); end
      step();
      rx_valid = 1'b0;
      drive(32'h00010, 1'b0, 8'h00);
      checks++; if (cpu_dout !== 8'h41) begin errors++; $display("FAIL rx_data: got %h want 41", cpu_dout); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_single_pulse: got %b want 0", rx_ready); end
   endtask

   task automatic test_tx_full();
      logic [7:0] want;
      tx_ready = 1'b0;
      txlog.delete();
      for (int i = 0; i < 8; i++) begin
         drive(32'h30000, 1'b1, 8'h31 + 8'(i));
         checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL tx_push_rdy[%0d]: got %b want 1", i, cpu_rdy); end
         step();
      end
      drive(32'h30000, 1'b1, 8'h39);
      for (int i = 0; i < 2; i++) begin
         checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL tx_full_rdy[%0d]: got %b want 0", i, cpu_rdy); end
         step();
      end
      tx_ready = 1'b1;
      #1;
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL tx_full_pop_rdy: got %b want 0", cpu_rdy); end
      step();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL tx_slot_rdy: got %b want 1", cpu_rdy); end
      step();
      drive(32'h00010, 1'b0, 8'h00);
      for (int k = 0; k < 40 && tx_valid; k++) step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drain: tx_valid got %b want 0 after 40 cycles", tx_valid); end
      checks++; if (txlog.size() != 9) begin errors++; $display("FAIL tx_count: got %0d want 9", txlog.size()); end
      for (int i = 0; i < 9; i++) begin
         want = 8'h31 + 8'(i);
         checks++;
         if (i >= txlog.size()) begin
            errors++; $display("FAIL tx_order[%0d]: got none want %h", i, want);
         end else if (txlog[i] !== want) begin
            errors++; $display("FAIL tx_order[%0d]: got %h want %h", i, txlog[i], want);
         end
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_io_misc();
      drive(32'h30000, 1'b1, 8'h00);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL tx_zero_rdy: got %b want 1", cpu_rdy); end
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_zero_valid: got %b want 0", tx_valid); end
      drive(32'h30008, 1'b1, 8'h55);
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_wr: tx_valid got %b want 0", tx_valid); end
      checks++; if (program_done !== 1'b0) begin errors++; $display("FAIL io_other_done: got %b want 0", program_done); end
      drive(32'h00010, 1'b0, 8'h00);
      step();
      drive(32'h3000C, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL io_other_rd: got %h want 00", cpu_dout); end
   endtask

   task automatic test_program_done();
      tx_ready = 1'b0;
      drive(32'h30004, 1'b1, 8'h77);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL done_rdy: got %b want 1", cpu_rdy); end
      step();
      checks++; if (program_done !== 1'b1) begin errors++; $display("FAIL done_set: got %b want 1", program_done); end
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL done_tx_valid: got %b want 1", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL done_tx_data: got %h want 00", tx_data); end
      drive(32'h30000, 1'b1, 8'h55);
      step();
      drive(32'h00010, 1'b0, 8'h00);
      step();
      checks++; if (program_done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", program_done); end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      #1;
      checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL done_next_byte: got %h want 55", tx_data); end
      rst_in = 1'b1;
      rx_valid = 1'b1;
      drive(32'h30000, 1'b0, 8'h00);
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_ready: got %b want 0", rx_ready); end
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy: got %b want 0", cpu_rdy); end
      step();
      checks++; if (program_done !== 1'b0) begin errors++; $display("FAIL rst_done_clr: got %b want 0", program_done); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_clr: got %b want 0", tx_valid); end
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL rst_dout2: got %h want 00", cpu_dout); end
      rx_valid = 1'b0;
      rst_in = 1'b0;
      drive(32'h00010, 1'b0, 8'h00);
      step();
      checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL ram_keep: got %h want a5", cpu_dout); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_tx: got %b want 0", tx_valid); end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_ram();
      test_rx_stall();
      test_tx_full();
      test_io_misc();
      test_program_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17: RAM address width; RAM size is 2^RAM_AW bytes (128 KB).
REQ-002 Parameter TX_DEPTH, default 8: tx FIFO depth in bytes; power of two, at least 2.
REQ-003 clk_in  input  1: the block's only clock; all state updates on its rising edge.
REQ-004 rst_in  input  1: reset, synchronous and active-high.
REQ-005 cpu_a  input  32: byte address from the CPU; only bits [17:0] are decoded.
REQ-006 cpu_din  input  8: write data from the CPU.
REQ-007 cpu_wr  input  1: 1 = write, 0 = read.
REQ-008 cpu_dout  output  8: registered read data returned to the CPU.
REQ-009 cpu_rdy  output  1: combinational ready/pause to the CPU; low means the CPU is frozen and holds cpu_a, cpu_din and cpu_wr stable.
REQ-010 rx_data  input  8: received UART byte.
REQ-011 rx_valid  input  1: rx_data holds a valid byte.
REQ-012 rx_ready  output  1: pops rx_data; pulses for one cycle per accepted byte.
REQ-013 tx_data  output  8: head byte of the tx FIFO.
REQ-014 tx_valid  output  1: tx FIFO is not empty.
REQ-015 tx_ready  input  1: UART accepts tx_data on any edge where tx_valid and tx_ready are both 1.
REQ-016 program_done  output  1: sticky flag; the program has stopped.

Function
REQ-017 Address decode: cpu_a[17:16]==2'b11 selects I/O; any other value selects RAM at cpu_a[RAM_AW-1:0].
REQ-018 RAM read: a request sampled at edge N drives the RAM byte on cpu_dout after edge N, so data is valid in cycle N+1 (latency 1).
REQ-019 RAM write: a request sampled at edge N updates the RAM at edge N; no wait cycle; cpu_dout is unchanged.
REQ-020 Read-after-write to the same address in consecutive cycles returns the new data.
REQ-021 Read 0x30000 with rx_valid=1: rx_ready is 1 in that cycle, and rx_data appears on cpu_dout after the edge.
REQ-022 Read 0x30000 with rx_valid=0: cpu_rdy=0 and rx_ready=0; the request is not accepted; it completes in the first cycle rx_valid=1.
REQ-023 Write 0x30000 with cpu_din!=0: the byte is pushed into the tx FIFO. When the FIFO is full, cpu_rdy=0 until a slot frees.
REQ-024 Write 0x30000 with cpu_din==0x00: ignored; no push and no stall.
REQ-025 Simultaneous push and pop on a full FIFO: cpu_rdy stays 0 in that cycle; the push is accepted in the following cycle. Push and pop on a non-full FIFO proceed in the same cycle.
REQ-026 The FIFO pointers are log2(TX_DEPTH)+1 bits wide and wrap modulo 2*TX_DEPTH. Full means the pointers are equal except for the MSB.
REQ-027 A free-running 32-bit cycle counter increments every cycle rst_in=0 and wraps from 0xFFFFFFFF to 0.
REQ-028 Read 0x30004: the counter value at that edge is latched into a 32-bit snapshot, and byte 0 of the value is returned.
REQ-029 Reads of 0x30005, 0x30006 and 0x30007 return snapshot bytes 1, 2 and 3 (little-endian); they do not re-latch the snapshot.
REQ-030 Write 0x30004 sets program_done=1 and pushes 0x00 into the tx FIFO, stalling on full as in REQ-023.
REQ-031 Once set, program_done stays 1 until reset.
REQ-032 Reads of any other I/O address return 0x00 with latency 1; writes to any other I/O address are ignored.
REQ-033 cpu_rdy = !rst_in AND no unmet rx read (REQ-022) AND no unmet tx push (REQ-023/REQ-030).
REQ-034 While cpu_rdy=0: no RAM write, no counter snapshot, no FIFO push, and cpu_dout holds its value.

Reset
REQ-035 While rst_in=1: cpu_dout=0x00, cpu_rdy=0, rx_ready=0, tx_valid=0, program_done=0, cycle counter=0, snapshot=0.
REQ-036 Reset empties the tx FIFO; bytes in flight are discarded.
REQ-037 RAM contents are not cleared by reset.
REQ-038 Reset asserted mid-stall abandons the pending request.
REQ-039 The counter reads 0 in the first cycle after reset deasserts.

Verification
REQ-040 Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> cpu_dout=0xA5 one cycle after the read is sampled.
REQ-041 Read 0x30000 with rx_valid=0 for 5 cycles, then rx_valid=1 with rx_data=0x41 -> cpu_rdy=0 for 5 cycles, single rx_ready pulse, cpu_dout=0x41.
REQ-042 tx_ready=0, TX_DEPTH=8, nine writes of 0x31 to 0x30000 -> eight accepted, cpu_rdy=0 on the ninth; set tx_ready=1 -> ninth byte accepted, nine bytes emitted in order.
REQ-043 Write 0x00 to 0x30000 -> tx_valid remains 0 and cpu_rdy remains 1.
REQ-044 Release reset, wait 0x1233 cycles, read 0x30004..0x30007 -> bytes 0x33, 0x12, 0x00, 0x00 (snapshot taken at the 0x30004 read).
REQ-045 Write 0x30004 -> program_done=1 and tx_data=0x00 delivered; reset -> program_done=0 and tx_valid=0.
